// File: rtl/cpu_arb_pkg.sv
// Shared types and encodings for the memory-port arbiter.
package cpu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_mux2.sv
// Generic 2:1 select; ctrl=0 passes in0, ctrl=1 passes in1.
module mem_port_arbiter_mux2 #(
    parameter int N = 1
) (
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    input  logic         ctrl,
    output logic [N-1:0] y
);

    assign y = ctrl ? in1 : in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single-ported memory with req/ack handshake.
// Build option: ARB_FIXED_PRIO_EN makes A win every tie instead of round-robin.
module mem_port_arbiter
    import cpu_arb_pkg::*;
#(
    parameter int N  = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [N-1:0]  wdata_a,
    input  logic          req_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [N-1:0]  wdata_b,
    output logic          done_a,
    output logic          done_b,
    output logic [N-1:0]  rdata,
    output logic          sel,
    output logic          busy,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [N-1:0]  mem_wdata,
    input  logic          mem_ack,
    input  logic [N-1:0]  mem_rdata
);

    state_t        state;
    logic          grant_b;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [N-1:0]  cmd_wdata;

`ifdef ARB_FIXED_PRIO_EN
    assign grant_b = req_b & ~req_a;
`else
    // last starts at B so that A takes the very first tie
    logic last;
    assign grant_b = req_b & (~req_a | (last == SEL_A));
`endif

    mem_port_arbiter_mux2 #(.N(1)) u_mux_we (
        .in0(we_a), .in1(we_b), .ctrl(grant_b), .y(cmd_we)
    );
    mem_port_arbiter_mux2 #(.N(AW)) u_mux_addr (
        .in0(addr_a), .in1(addr_b), .ctrl(grant_b), .y(cmd_addr)
    );
    mem_port_arbiter_mux2 #(.N(N)) u_mux_wdata (
        .in0(wdata_a), .in1(wdata_b), .ctrl(grant_b), .y(cmd_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
`ifndef ARB_FIXED_PRIO_EN
            last      <= SEL_B;
`endif
            sel       <= SEL_A;
            busy      <= 1'b0;
            done_a    <= 1'b0;
            done_b    <= 1'b0;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            done_a <= 1'b0;
            done_b <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (req_a | req_b) begin
                        sel       <= grant_b;
`ifndef ARB_FIXED_PRIO_EN
                        last      <= grant_b;
`endif
                        mem_we    <= cmd_we;
                        mem_addr  <= cmd_addr;
                        mem_wdata <= cmd_wdata;
                        mem_req   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Command stays frozen until the memory acknowledges
                    if (mem_ack) begin
                        rdata   <= mem_rdata;
                        mem_req <= 1'b0;
                        done_a  <= (sel == SEL_A);
                        done_b  <= (sel == SEL_B);
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: randomized requesters and memory, transaction-level model.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r_req [2];
    logic        r_we [2];
    logic [31:0] r_addr [2];
    logic [31:0] r_wdata [2];
    logic        req_a, we_a, req_b, we_b;
    logic [31:0] addr_a, wdata_a, addr_b, wdata_b;
    logic        done_a, done_b, sel, busy, mem_req, mem_we, mem_ack;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

    assign req_a = r_req[0];   assign req_b = r_req[1];
    assign we_a = r_we[0];     assign we_b = r_we[1];
    assign addr_a = r_addr[0]; assign addr_b = r_addr[1];
    assign wdata_a = r_wdata[0]; assign wdata_b = r_wdata[1];

    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .done_a(done_a), .done_b(done_b), .rdata(rdata), .sel(sel), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Pending commands per requester, oldest first
    cmd_t qa[$];
    cmd_t qb[$];
    int   g_who[$];
    int   g_cyc[$];

    // Memory responder: mode 0 random latency plus spurious acks, mode 1 fixed latency
    int          ack_mode = 1;
    int          ack_lat = 1;
    logic [31:0] fix_rdata = 32'h0;
    int          req_cnt = 0;
    always @(posedge clk) begin
        #1;
        req_cnt = mem_req ? req_cnt + 1 : 0;
        if (ack_mode == 0) begin
            mem_ack   = mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
            mem_rdata = $urandom;
        end else begin
            mem_ack   = mem_req && (req_cnt == ack_lat);
            mem_rdata = mem_ack ? fix_rdata : $urandom;
        end
    end

    // Transaction-level reference: the port is either free or serving one owner;
    // a transaction ends the cycle after the ack, and one idle cycle follows before a new grant.
    bit          mon_en = 0;
    bit          m_free = 1;
    bit          m_gnt = 0;
    bit          m_done_exp = 0;
    bit          m_last = 1;
    bit          m_owner = 0;
    cmd_t        m_cmd;
    logic [31:0] m_rdata;

    always @(negedge clk) begin
        bit pa, pb, w;
        if (mon_en) begin
            if (m_done_exp) begin
                m_done_exp = 0;
                chk("done_a", {31'd0, done_a}, {31'd0, m_owner == 1'b0});
                chk("done_b", {31'd0, done_b}, {31'd0, m_owner == 1'b1});
                chk("rdata", rdata, m_rdata);
                chk("done_sel", {31'd0, sel}, {31'd0, m_owner});
                chk("done_mem_req", {31'd0, mem_req}, 32'd0);
                if (m_owner) begin if (qb.size() > 0) qb.delete(0); end
                else begin if (qa.size() > 0) qa.delete(0); end
                m_free = 1;
            end else if (m_free) begin
                chk("idle_busy", {31'd0, busy}, 32'd0);
                chk("idle_mem_req", {31'd0, mem_req}, 32'd0);
                chk("idle_done", {30'd0, done_a, done_b}, 32'd0);
                pa = req_a;
                pb = req_b;
                if (pa || pb) begin
`ifdef ARB_FIXED_PRIO_EN
                    w = !pa;
`else
                    w = (pa && pb) ? !m_last : pb;
`endif
                    m_last  = w;
                    m_owner = w;
                    if ((w ? qb.size() : qa.size()) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_empty: request seen with no issued command, requester %0d", w);
                    end else begin
                        m_cmd = w ? qb[0] : qa[0];
                    end
                    m_free = 0;
                    m_gnt  = 1;
                end
            end else begin
                if (m_gnt) begin
                    m_gnt = 0;
                    g_who.push_back(int'(m_owner));
                    g_cyc.push_back(cyc);
                    chk("gnt_sel", {31'd0, sel}, {31'd0, m_owner});
                end
                chk("bsy_mem_req", {31'd0, mem_req}, 32'd1);
                chk("bsy_busy", {31'd0, busy}, 32'd1);
                chk("bsy_done", {30'd0, done_a, done_b}, 32'd0);
                chk("bsy_mem_we", {31'd0, mem_we}, {31'd0, m_cmd.we});
                chk("bsy_mem_addr", mem_addr, m_cmd.addr);
                chk("bsy_mem_wdata", mem_wdata, m_cmd.wdata);
                if (mem_ack) begin
                    m_done_exp = 1;
                    m_rdata    = mem_rdata;
                end
            end
        end
    end

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.we    = 1'($urandom_range(0, 1));
        c.addr  = $urandom;
        c.wdata = $urandom;
        return c;
    endfunction

    task automatic issue(input int i, input cmd_t c);
        r_we[i]    = c.we;
        r_addr[i]  = c.addr;
        r_wdata[i] = c.wdata;
        r_req[i]   = 1'b1;
        if (i == 0) qa.push_back(c);
        else qb.push_back(c);
    endtask

    function automatic logic done_of(input int i);
        return (i == 0) ? done_a : done_b;
    endfunction

    // Random requester: gaps of 0 (request held through DONE) to 3 cycles,
    // inputs scrambled and request sometimes dropped after the grant.
    task automatic drive(input int i, input int n);
        int  t;
        bit  got;
        repeat (n) begin
            int gap = $urandom_range(0, 3);
            if (gap > 0) begin
                r_req[i] = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            issue(i, rand_cmd());
            got = 0;
            t = 0;
            forever begin
                @(posedge clk); #1;
                t++;
                if (done_of(i)) break;
                if (t > 400) begin
                    checks++; errors++;
                    $display("FAIL drv_timeout: requester %0d got %0d cycles want done", i, t);
                    break;
                end
                if (!got && mem_req && sel == 1'(i)) begin
                    got = 1;
                    r_addr[i]  = $urandom;
                    r_wdata[i] = $urandom;
                    r_we[i]    = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 3) == 0) r_req[i] = 1'b0;
                end
            end
        end
        r_req[i] = 1'b0;
    endtask

    // Re-issue on done until ngr grants are logged, then let both queues drain.
    task automatic pump(input int ngr, input int maxc);
        int c = 0;
        forever begin
            @(posedge clk); #1;
            c++;
            for (int i = 0; i < 2; i++) begin
                if (done_of(i)) begin
                    if (g_who.size() < ngr) issue(i, rand_cmd());
                    else r_req[i] = 1'b0;
                end
            end
            if (g_who.size() >= ngr && qa.size() == 0 && qb.size() == 0) break;
            if (c > maxc) begin
                checks++; errors++;
                $display("FAIL pump_timeout: got %0d grants want %0d", g_who.size(), ngr);
                break;
            end
        end
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;
    endtask

    task automatic model_reset();
        qa.delete(); qb.delete(); g_who.delete(); g_cyc.delete();
        m_free = 1; m_gnt = 0; m_done_exp = 0; m_last = 1; m_owner = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int n, t;
        bit g;
        for (int i = 0; i < 2; i++) begin
            r_req[i] = 0; r_we[i] = 0; r_addr[i] = 0; r_wdata[i] = 0;
        end
        mem_ack = 0; mem_rdata = 0;
        rst_n = 0;
        #3;
        chk("rst_sel", {31'd0, sel}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {30'd0, done_a, done_b}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);

        // Both requesters held from reset, single-cycle memory
        ack_mode = 1; ack_lat = 1;
        issue(0, rand_cmd());
        issue(1, rand_cmd());
        repeat (2) @(posedge clk);
        #1; rst_n = 1; mon_en = 1;
        pump(4, 200);
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            chk("rr_order", g_who[k], 0);
`else
            chk("rr_order", g_who[k], k % 2);
`endif
            if (k > 0) chk("rr_spacing", g_cyc[k] - g_cyc[k-1], 3);
        end

        // Single A read, ack in the third BUSY cycle
        ack_lat = 3; fix_rdata = 32'hDEADBEEF;
        issue(0, '{we: 1'b0, addr: 32'h40, wdata: 32'h0});
        n = 0; t = 0;
        forever begin
            @(posedge clk); #1;
            t++;
            if (done_a || t > 50) break;
            if (mem_req) begin
                n++;
                chk("a_read_addr", mem_addr, 32'h40);
            end
        end
        r_req[0] = 0;
        chk("a_read_req_cycles", n, 3);
        chk("a_read_done", {31'd0, done_a}, 32'd1);
        chk("a_read_rdata", rdata, 32'hDEADBEEF);
        chk("a_read_sel", {31'd0, sel}, 32'd0);
        @(posedge clk); #1;

        // B write with its inputs changed right after the grant
        fix_rdata = 32'h0BADF00D;
        issue(1, '{we: 1'b1, addr: 32'h100, wdata: 32'h12345678});
        g = 0; t = 0;
        forever begin
            @(posedge clk); #1;
            t++;
            if (done_b || t > 50) break;
            if (mem_req) begin
                if (!g) begin g = 1; r_wdata[1] = 0; r_addr[1] = 0; r_we[1] = 0; end
                chk("b_wr_wdata", mem_wdata, 32'h12345678);
                chk("b_wr_we", {31'd0, mem_we}, 32'd1);
                chk("b_wr_addr", mem_addr, 32'h100);
            end
        end
        r_req[1] = 0;
        chk("b_wr_done_b", {31'd0, done_b}, 32'd1);
        chk("b_wr_done_a", {31'd0, done_a}, 32'd0);
        @(posedge clk); #1;

        // Randomized traffic: random latency, spurious acks, drops, back-to-back requests
        ack_mode = 0;
        fork
            drive(0, 40);
            drive(1, 40);
        join
        repeat (3) @(posedge clk);
        #1;
        chk("rand_qa_drained", qa.size(), 0);
        chk("rand_qb_drained", qb.size(), 0);

        // Asynchronous reset in the middle of a BUSY cycle
        ack_mode = 1; ack_lat = 20;
        issue(1, rand_cmd());
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!mem_req && t < 20);
        chk("rstb_granted", {31'd0, mem_req}, 32'd1);
        #3;
        mon_en = 0;
        rst_n = 0;
        #1;
        chk("rstb_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rstb_busy", {31'd0, busy}, 32'd0);
        chk("rstb_sel", {31'd0, sel}, 32'd0);
        r_req[0] = 0; r_req[1] = 0;
        model_reset();
        repeat (2) begin
            @(posedge clk); #1;
            chk("rstb_no_done", {30'd0, done_a, done_b}, 32'd0);
        end
        ack_mode = 0;
        issue(0, rand_cmd());
        issue(1, rand_cmd());
        rst_n = 1; mon_en = 1;
        pump(0, 200);
        chk("rstb_first_grant_a", (g_who.size() > 0) ? g_who[0] : -1, 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
